// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a request/response handshake, configurable
// wait states before each response, per-byte store lanes and access-error flagging.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;

    logic          accept;
    logic          enter_resp;
    logic          leave_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    assign req_ready  = (state_reg == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign leave_resp = (state_reg == RESP) && resp_ready;
    assign enter_resp = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                                 ((state_reg == WAIT) && (cnt_reg == 4'd0)));

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the access must be taken from the live request, not the capture registers.
    always_comb begin
        acc_we    = we_reg;
        acc_addr  = addr_reg;
        acc_be    = be_reg;
        acc_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_be    = req_byte_enable;
            acc_wdata = req_wdata;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            we_reg         <= 1'b0;
            addr_reg       <= 32'd0;
            be_reg         <= 4'd0;
            wdata_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        be_reg    <= req_byte_enable;
                        wdata_reg <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= acc_err;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= acc_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;

    // One byte-wide array per lane so each lane maps onto its own RAM write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (enter_resp && acc_we && !acc_err && acc_be[gi]) begin
                mem[acc_idx] <= acc_wdata[8*gi +: 8];
            end
            if (rst || leave_resp) begin
                rd_byte_reg <= 8'h00;
            end else if (enter_resp) begin
                rd_byte_reg <= (!acc_we && !acc_err) ? mem[acc_idx] : 8'h00;
            end
        end

        assign resp_rdata[8*gi +: 8] = rd_byte_reg;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut1 (one wait state) carries the main transactions, dut0 (no wait
// states) shadows them and is then used alone for back-to-back throughput.
module tb_data_mem_responder;

    localparam int WAIT1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byte_enable;
    logic [31:0] req_wdata;
    logic        resp_ready, resp_ready0;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_byte_enable(req_byte_enable), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_byte_enable(req_byte_enable), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_valid0 = 1'b1;
        req_we = we; req_addr = addr; req_byte_enable = be; req_wdata = wdata;
        resp_ready = 1'b0; resp_ready0 = 1'b0;
        @(posedge clk); #1;
        // Scramble the request so any missed capture shows up in the response.
        req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = ~we; req_addr = 32'h0000_0014; req_byte_enable = ~be; req_wdata = ~wdata;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 20);
        check({tag, " latency"}, 32'(k), 32'(WAIT1 + 1));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold rdata"}, resp_rdata, exp_rdata);
            check({tag, " hold err"}, 32'(resp_err), 32'(exp_err));
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1; resp_ready0 = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; resp_ready0 = 1'b0;
        @(negedge clk);
        check({tag, " done valid"}, 32'(resp_valid), 32'd0);
        check({tag, " done rdata"}, resp_rdata, 32'd0);
        check({tag, " done err"}, 32'(resp_err), 32'd0);
        check({tag, " idle ready"}, 32'(req_ready), 32'd1);
        $display("txn %s we=%0d addr=%h be=%b wdata=%h -> rdata=%h err=%0d", tag, we, addr, be,
                 wdata, exp_rdata, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_byte_enable = 4'd0; req_wdata = 32'd0; resp_ready = 1'b0; resp_ready0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset valid", 32'(resp_valid), 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset err", 32'(resp_err), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        txn("st10",   1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        txn("ld10",   1'b0, 32'h10, 4'b0000, 32'h0,        0, 32'hDEADBEEF, 1'b0);
        txn("st20",   1'b1, 32'h20, 4'b1111, 32'h11223344, 0, 32'h0, 1'b0);
        txn("st20b2", 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 0, 32'h0, 1'b0);
        txn("ld20",   1'b0, 32'h20, 4'b1111, 32'h0,        0, 32'h11AA3344, 1'b0);
        txn("ld22",   1'b0, 32'h22, 4'b1111, 32'h0,        0, 32'h0, 1'b1);
        txn("ld400",  1'b0, 32'h400, 4'b1111, 32'h0,       0, 32'h0, 1'b1);
        txn("st22",   1'b1, 32'h22, 4'b1111, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
        txn("ld20chk",1'b0, 32'h20, 4'b0000, 32'h0,        0, 32'h11AA3344, 1'b0);
        txn("st10be0",1'b1, 32'h10, 4'b0000, 32'h12345678, 0, 32'h0, 1'b0);
        txn("ld10bp", 1'b0, 32'h10, 4'b0000, 32'h0,        5, 32'hDEADBEEF, 1'b0);
        txn("st30",   1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, 0, 32'h0, 1'b0);

        // Store aborted by reset on the edge that would have entered RESP.
        req_valid = 1'b1; req_valid0 = 1'b1; req_we = 1'b1; req_addr = 32'h30;
        req_byte_enable = 4'b1111; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst valid", 32'(resp_valid), 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        txn("ld30", 1'b0, 32'h30, 4'b0000, 32'h0, 0, 32'hCAFEF00D, 1'b0);

        // Back-to-back loads on the zero-wait instance, alternating words.
        req_valid0 = 1'b1; resp_ready0 = 1'b1; req_we = 1'b0; req_byte_enable = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) req_addr = ((i / 2) % 2 == 1) ? 32'h20 : 32'h10;
            check("b2b req_ready", 32'(req_ready0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b valid", 32'(resp_valid0), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) begin
                check("b2b rdata", resp_rdata0,
                      ((i / 2) % 2 == 1) ? 32'h11AA3344 : 32'hDEADBEEF);
                check("b2b err", 32'(resp_err0), 32'd0);
                $display("txn b2b addr=%h rdata=%h", req_addr, resp_rdata0);
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0; resp_ready0 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
